// File: rtl/enc_hold_seg.sv
// enc_hold_seg
//   Downstream stage of the 8-to-3 priority encoder. It filters glitches on the
//   encoder's {t, y} outputs, holds the last stable valid code, and drives that
//   code to an active-low 7-segment digit. It also counts accepted valid codes
//   for a status display.
//
// Parameters
//   STABLE_CYC : number of consecutive identical samples needed to accept a new
//                {t,y}. Must be >= 1.
//   CNT_W      : width of the event counter.
//
// Ports
//   clk        : system clock; all state changes happen on its rising edge
//   rst_n      : asynchronous reset, active-low
//   t_in       : encoder valid flag
//   y_in[2:0]  : encoder code; treated as 0 whenever t_in=0
//   clr        : synchronous clear of the held code, counter and history
//   valid_o    : 1 while a stable valid code is held
//   code_o     : held code; 0 when valid_o=0
//   seg_o      : active-low segments {g,f,e,d,c,b,a}; blank (all ones) when invalid
//   changed_o  : one-cycle pulse on the cycle a new valid code is committed
//   evt_cnt_o  : number of valid commits; saturates at all-ones
//   dp_o       : only when ENC_HOLD_DP_EN is defined. Active-low decimal point,
//                driven 0 while evt_cnt_o is saturated.
//
// Build option
//   ENC_HOLD_DP_EN : adds the dp_o saturation indicator port.

module enc_hold_seg #(
  parameter int STABLE_CYC = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             t_in,
  input  logic [2:0]       y_in,
  input  logic             clr,
  output logic             valid_o,
  output logic [2:0]       code_o,
  output logic [6:0]       seg_o,
  output logic             changed_o,
`ifdef ENC_HOLD_DP_EN
  output logic [CNT_W-1:0] evt_cnt_o,
  output logic             dp_o
`else
  output logic [CNT_W-1:0] evt_cnt_o
`endif
);

  localparam int              RUN_W   = $clog2(STABLE_CYC + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYC);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_QUAL  = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       last_q, last_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             valid_q, valid_d;
  logic [2:0]       code_q, code_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]       sample;
  logic [3:0]       committed;
  logic [RUN_W-1:0] run_inc;
  logic             commit;

  // The sample history is kept as the last sample plus the length of its
  // current run, saturated at STABLE_CYC. A cleared history is a full run of
  // {t=0,y=0}, so a run length of RUN_MAX is the reset value. A commit happens
  // when the run is full and the sample differs from what is currently held.
  // A held invalid state is represented as {0,0}.
  always_comb begin
    sample    = {t_in, (t_in ? y_in : 3'd0)};
    committed = {valid_q, code_q};

    if (sample == last_q) begin
      run_inc = (run_q >= RUN_MAX) ? RUN_MAX : run_q + RUN_W'(1);
    end else begin
      run_inc = RUN_W'(1);
    end

    commit = (run_inc == RUN_MAX) && (sample != committed);
  end

  // Next-state logic for the FSM and the held outputs. QUAL only holds the
  // outputs frozen. The run counter does the actual qualification.
  // clr has the highest priority, so it suppresses a commit on the same edge.
  always_comb begin
    state_d   = state_q;
    last_d    = sample;
    run_d     = run_inc;
    valid_d   = valid_q;
    code_d    = code_q;
    changed_d = 1'b0;
    cnt_d     = cnt_q;

    if (commit) begin
      valid_d   = sample[3];
      code_d    = sample[2:0];
      changed_d = sample[3];
      state_d   = sample[3] ? ST_HOLD : ST_EMPTY;
      if (sample[3] && !(&cnt_q)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      case (state_q)
        ST_EMPTY, ST_HOLD: begin
          if (sample != committed) begin
            state_d = ST_QUAL;
          end
        end
        ST_QUAL: begin
          if (sample == committed) begin
            state_d = valid_q ? ST_HOLD : ST_EMPTY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    if (clr) begin
      state_d   = ST_EMPTY;
      last_d    = 4'd0;
      run_d     = RUN_MAX;
      valid_d   = 1'b0;
      code_d    = 3'd0;
      changed_d = 1'b0;
      cnt_d     = '0;
    end
  end

  // State register. An asynchronous reset discards any partial qualification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      last_q    <= 4'd0;
      run_q     <= RUN_MAX;
      valid_q   <= 1'b0;
      code_q    <= 3'd0;
      changed_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      run_q     <= run_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
    end
  end

  // Segment decode of the registered code. Segments are active-low.
  always_comb begin
    case (code_q)
      3'd0:    seg_o = 7'b1000000;
      3'd1:    seg_o = 7'b1111001;
      3'd2:    seg_o = 7'b0100100;
      3'd3:    seg_o = 7'b0110000;
      3'd4:    seg_o = 7'b0011001;
      3'd5:    seg_o = 7'b0010010;
      3'd6:    seg_o = 7'b0000010;
      default: seg_o = 7'b1111000;
    endcase
    if (!valid_q) begin
      seg_o = 7'b1111111;
    end
  end

  assign valid_o   = valid_q;
  assign code_o    = code_q;
  assign changed_o = changed_q;
  assign evt_cnt_o = cnt_q;

`ifdef ENC_HOLD_DP_EN
  assign dp_o = ~(&cnt_q);
`endif

endmodule

// File: tb/tb_enc_hold_seg.sv
// Testbench for enc_hold_seg.
// The main instance uses the default parameters (STABLE_CYC=4, CNT_W=8).
// A second instance uses STABLE_CYC=1 and CNT_W=2 to exercise
// first-edge commits and counter saturation.

module tb_enc_hold_seg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       t_in = 1'b0;
  logic [2:0] y_in = 3'd0;
  logic       clr = 1'b0;
  logic       valid_o;
  logic [2:0] code_o;
  logic [6:0] seg_o;
  logic       changed_o;
  logic [7:0] evt_cnt_o;

  logic       t2 = 1'b0;
  logic [2:0] y2 = 3'd0;
  logic       clr2 = 1'b0;
  logic       valid2;
  logic [2:0] code2;
  logic [6:0] seg2;
  logic       changed2;
  logic [1:0] cnt2;

`ifdef ENC_HOLD_DP_EN
  logic dp_o;
  logic dp2;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  enc_hold_seg #(.STABLE_CYC(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .t_in(t_in), .y_in(y_in), .clr(clr),
    .valid_o(valid_o), .code_o(code_o), .seg_o(seg_o), .changed_o(changed_o),
`ifdef ENC_HOLD_DP_EN
    .evt_cnt_o(evt_cnt_o), .dp_o(dp_o)
`else
    .evt_cnt_o(evt_cnt_o)
`endif
  );

  enc_hold_seg #(.STABLE_CYC(1), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .t_in(t2), .y_in(y2), .clr(clr2),
    .valid_o(valid2), .code_o(code2), .seg_o(seg2), .changed_o(changed2),
`ifdef ENC_HOLD_DP_EN
    .evt_cnt_o(cnt2), .dp_o(dp2)
`else
    .evt_cnt_o(cnt2)
`endif
  );

  // Advance one rising edge, then move 1 time unit past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    t_in = 1'b0; y_in = 3'd0; clr = 1'b0;
    repeat (2) tick();
    #2 rst_n = 1'b1;
    tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b want 0", valid_o); end
    checks++; if (code_o !== 3'd0) begin errors++; $display("[TB] FAIL reset_code: got %0d want 0", code_o); end
    checks++; if (seg_o !== 7'h7F) begin errors++; $display("[TB] FAIL reset_seg: got %b want 1111111", seg_o); end
    checks++; if (evt_cnt_o !== 8'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d want 0", evt_cnt_o); end
    checks++; if (changed_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_changed: got %0b want 0", changed_o); end
  endtask

  task automatic test_stable_commit();
    t_in = 1'b1; y_in = 3'd5;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL early_valid edge %0d: got %0b want 0", i, valid_o); end
    end
    tick();
    checks++; if (valid_o !== 1'b1) begin errors++; $display("[TB] FAIL commit5_valid: got %0b want 1", valid_o); end
    checks++; if (code_o !== 3'd5) begin errors++; $display("[TB] FAIL commit5_code: got %0d want 5", code_o); end
    checks++; if (seg_o !== 7'b0010010) begin errors++; $display("[TB] FAIL commit5_seg: got %b want 0010010", seg_o); end
    checks++; if (changed_o !== 1'b1) begin errors++; $display("[TB] FAIL commit5_pulse: got %0b want 1", changed_o); end
    checks++; if (evt_cnt_o !== 8'd1) begin errors++; $display("[TB] FAIL commit5_cnt: got %0d want 1", evt_cnt_o); end
    tick();
    checks++; if (changed_o !== 1'b0) begin errors++; $display("[TB] FAIL commit5_pulse_width: got %0b want 0", changed_o); end
  endtask

  task automatic test_glitch();
    logic [2:0] ys [6] = '{3'd2, 3'd2, 3'd5, 3'd5, 3'd5, 3'd5};
    for (int i = 0; i < 6; i++) begin
      y_in = ys[i];
      tick();
      checks++; if (changed_o !== 1'b0) begin errors++; $display("[TB] FAIL glitch_pulse step %0d: got %0b want 0", i, changed_o); end
      checks++; if (code_o !== 3'd5) begin errors++; $display("[TB] FAIL glitch_code step %0d: got %0d want 5", i, code_o); end
    end
    checks++; if (evt_cnt_o !== 8'd1) begin errors++; $display("[TB] FAIL glitch_cnt: got %0d want 1", evt_cnt_o); end
  endtask

  task automatic test_invalid_then_valid();
    t_in = 1'b0; y_in = 3'd3;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (valid_o !== 1'b1) begin errors++; $display("[TB] FAIL inv_hold edge %0d: got %0b want 1", i, valid_o); end
    end
    tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL inv_valid: got %0b want 0", valid_o); end
    checks++; if (code_o !== 3'd0) begin errors++; $display("[TB] FAIL inv_code: got %0d want 0", code_o); end
    checks++; if (seg_o !== 7'h7F) begin errors++; $display("[TB] FAIL inv_seg: got %b want 1111111", seg_o); end
    checks++; if (changed_o !== 1'b0) begin errors++; $display("[TB] FAIL inv_pulse: got %0b want 0", changed_o); end
    checks++; if (evt_cnt_o !== 8'd1) begin errors++; $display("[TB] FAIL inv_cnt: got %0d want 1", evt_cnt_o); end
    t_in = 1'b1; y_in = 3'd7;
    repeat (3) tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL seven_early: got %0b want 0", valid_o); end
    tick();
    checks++; if (code_o !== 3'd7) begin errors++; $display("[TB] FAIL seven_code: got %0d want 7", code_o); end
    checks++; if (seg_o !== 7'b1111000) begin errors++; $display("[TB] FAIL seven_seg: got %b want 1111000", seg_o); end
    checks++; if (changed_o !== 1'b1) begin errors++; $display("[TB] FAIL seven_pulse: got %0b want 1", changed_o); end
    checks++; if (evt_cnt_o !== 8'd2) begin errors++; $display("[TB] FAIL seven_cnt: got %0d want 2", evt_cnt_o); end
  endtask

  task automatic test_saturate();
    logic [2:0] codes [4] = '{3'd1, 3'd2, 3'd1, 3'd2};
    logic [1:0] cnts  [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    t2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      y2 = codes[i];
      tick();
      checks++; if (code2 !== codes[i]) begin errors++; $display("[TB] FAIL sat_code %0d: got %0d want %0d", i, code2, codes[i]); end
      checks++; if (changed2 !== 1'b1) begin errors++; $display("[TB] FAIL sat_pulse %0d: got %0b want 1", i, changed2); end
      checks++; if (cnt2 !== cnts[i]) begin errors++; $display("[TB] FAIL sat_cnt %0d: got %0d want %0d", i, cnt2, cnts[i]); end
`ifdef ENC_HOLD_DP_EN
      checks++; if (dp2 !== (i < 2)) begin errors++; $display("[TB] FAIL sat_dp %0d: got %0b want %0b", i, dp2, (i < 2)); end
`endif
    end
    clr2 = 1'b1;
    tick();
    clr2 = 1'b0; t2 = 1'b0;
    checks++; if (cnt2 !== 2'd0) begin errors++; $display("[TB] FAIL sat_clr_cnt: got %0d want 0", cnt2); end
    checks++; if (valid2 !== 1'b0) begin errors++; $display("[TB] FAIL sat_clr_valid: got %0b want 0", valid2); end
    checks++; if (seg2 !== 7'h7F) begin errors++; $display("[TB] FAIL sat_clr_seg: got %b want 1111111", seg2); end
`ifdef ENC_HOLD_DP_EN
    checks++; if (dp2 !== 1'b1) begin errors++; $display("[TB] FAIL sat_clr_dp: got %0b want 1", dp2); end
`endif
  endtask

  task automatic test_clr_on_commit();
    t_in = 1'b1; y_in = 3'd1;
    repeat (3) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (changed_o !== 1'b0) begin errors++; $display("[TB] FAIL clr_pulse: got %0b want 0", changed_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL clr_valid: got %0b want 0", valid_o); end
    checks++; if (evt_cnt_o !== 8'd0) begin errors++; $display("[TB] FAIL clr_cnt: got %0d want 0", evt_cnt_o); end
    repeat (3) tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL clr_history: got %0b want 0", valid_o); end
    tick();
    checks++; if (code_o !== 3'd1) begin errors++; $display("[TB] FAIL post_clr_code: got %0d want 1", code_o); end
    checks++; if (seg_o !== 7'b1111001) begin errors++; $display("[TB] FAIL post_clr_seg: got %b want 1111001", seg_o); end
    checks++; if (evt_cnt_o !== 8'd1) begin errors++; $display("[TB] FAIL post_clr_cnt: got %0d want 1", evt_cnt_o); end
  endtask

  task automatic test_async_reset();
    y_in = 3'd4;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL arst_valid: got %0b want 0", valid_o); end
    checks++; if (code_o !== 3'd0) begin errors++; $display("[TB] FAIL arst_code: got %0d want 0", code_o); end
    checks++; if (seg_o !== 7'h7F) begin errors++; $display("[TB] FAIL arst_seg: got %b want 1111111", seg_o); end
    checks++; if (evt_cnt_o !== 8'd0) begin errors++; $display("[TB] FAIL arst_cnt: got %0d want 0", evt_cnt_o); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (changed_o !== 1'b0) begin errors++; $display("[TB] FAIL arst_pulse: got %0b want 0", changed_o); end
  endtask

  initial begin
    test_reset();
    test_stable_commit();
    test_glitch();
    test_invalid_then_valid();
    test_saturate();
    test_clr_on_commit();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
